// File: rtl/pc_sequencer_if.sv
// Bus between execute-stage redirect logic and the fetch PC sequencer.
// The master drives the redirect request; the slave returns the fetch address and its qualifiers.
interface pc_sequencer_if;
    logic        Stall;
    logic        ExValid;
    logic        Diverge;
    logic [31:0] Target;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstValid;
    logic        Flush;
    logic        Misaligned;
    logic [15:0] RedirectCount;

    modport master (
        output Stall, ExValid, Diverge, Target,
        input  PC, PCPlus4, InstValid, Flush, Misaligned, RedirectCount
    );

    modport slave (
        input  Stall, ExValid, Diverge, Target,
        output PC, PCPlus4, InstValid, Flush, Misaligned, RedirectCount
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the fetch PC and squashes wrong-path fetches after a taken redirect.
// Every output is registered, so no combinational path runs from Diverge to IMem.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_2000,
    parameter int          KILL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {START, RUN, FLUSH} state_t;

    localparam logic [1:0] KILL_RELOAD = 2'(KILL_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  kill_cnt, kill_cnt_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] pc_plus4_q;
    logic        inst_valid_q, inst_valid_nxt;
    logic        flush_q, flush_nxt;
    logic        misaligned_q, misaligned_nxt;
    logic [15:0] redir_cnt_q, redir_cnt_nxt;
    logic        redirect;

    // Bit 0 is dropped so JALR targets land on a halfword boundary.
    function automatic logic [31:0] effective_target(input logic [31:0] t);
        return t & 32'hFFFF_FFFE;
    endfunction

    assign redirect = bus.ExValid & bus.Diverge;

    always_comb begin
        state_nxt      = state;
        kill_cnt_nxt   = kill_cnt;
        pc_nxt         = pc_q;
        inst_valid_nxt = inst_valid_q;
        flush_nxt      = flush_q;
        misaligned_nxt = misaligned_q;
        redir_cnt_nxt  = redir_cnt_q;

        // A redirect beats Stall in RUN and restarts the squash window in FLUSH.
        if (state != START && redirect) begin
            pc_nxt         = effective_target(bus.Target);
            state_nxt      = FLUSH;
            kill_cnt_nxt   = KILL_RELOAD;
            flush_nxt      = 1'b1;
            inst_valid_nxt = 1'b0;
            redir_cnt_nxt  = redir_cnt_q + 16'd1;
            misaligned_nxt = misaligned_q | bus.Target[1];
        end else begin
            case (state)
                START: begin
                    if (!bus.Stall) begin
                        pc_nxt         = RESET_PC + 32'd4;
                        inst_valid_nxt = 1'b1;
                        state_nxt      = RUN;
                    end
                end
                RUN: begin
                    if (!bus.Stall) begin
                        pc_nxt         = pc_q + 32'd4;
                        inst_valid_nxt = 1'b1;
                    end
                end
                FLUSH: begin
                    pc_nxt         = pc_q + 32'd4;
                    inst_valid_nxt = 1'b1;
                    if (kill_cnt == 2'd0) begin
                        flush_nxt = 1'b0;
                        state_nxt = RUN;
                    end else begin
                        kill_cnt_nxt = kill_cnt - 2'd1;
                    end
                end
                default: state_nxt = START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= START;
            kill_cnt     <= 2'd0;
            pc_q         <= RESET_PC;
            pc_plus4_q   <= RESET_PC + 32'd4;
            inst_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
            redir_cnt_q  <= 16'd0;
        end else begin
            state        <= state_nxt;
            kill_cnt     <= kill_cnt_nxt;
            pc_q         <= pc_nxt;
            pc_plus4_q   <= pc_nxt + 32'd4;
            inst_valid_q <= inst_valid_nxt;
            flush_q      <= flush_nxt;
            misaligned_q <= misaligned_nxt;
            redir_cnt_q  <= redir_cnt_nxt;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.PCPlus4       = pc_plus4_q;
    assign bus.InstValid     = inst_valid_q;
    assign bus.Flush         = flush_q;
    assign bus.Misaligned    = misaligned_q;
    assign bus.RedirectCount = redir_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC    = 32'h0000_2000;
    localparam int          KILL_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC), .KILL_CYCLES(KILL_CYCLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: squash window tracked as "cycles of Flush still to show".
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_flush_left;
    logic        m_started;
    logic        m_mis;
    logic [15:0] m_count;

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_flush_left = 0;
        m_started = 1'b0; m_mis = 1'b0; m_count = 16'd0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (!m_started) begin
                if (!bus.Stall) begin
                    m_started = 1'b1; m_pc = RESET_PC + 32'd4; m_valid = 1'b1;
                end
            end else if (bus.ExValid && bus.Diverge) begin
                m_pc = {bus.Target[31:1], 1'b0};
                m_valid = 1'b0;
                m_flush_left = KILL_CYCLES;
                m_count = m_count + 16'd1;
                m_mis = m_mis | bus.Target[1];
            end else if (m_flush_left > 0) begin
                m_pc = m_pc + 32'd4; m_valid = 1'b1; m_flush_left--;
            end else if (!bus.Stall) begin
                m_pc = m_pc + 32'd4; m_valid = 1'b1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.Stall = 1'b0; bus.ExValid = 1'b0; bus.Diverge = 1'b0; bus.Target = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (bus.PC !== 32'h2000) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 32'h2000); end
        n_checks++; if (bus.PCPlus4 !== 32'h2004) begin n_errors++; $display("FAIL reset_pcplus4: got %h expected %h", bus.PCPlus4, 32'h2004); end
        n_checks++; if (bus.InstValid !== 1'b0) begin n_errors++; $display("FAIL reset_instvalid: got %b expected 0", bus.InstValid); end
        n_checks++; if (bus.Flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %b expected 0", bus.Flush); end
        n_checks++; if (bus.Misaligned !== 1'b0) begin n_errors++; $display("FAIL reset_misaligned: got %b expected 0", bus.Misaligned); end
        n_checks++; if (bus.RedirectCount !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.RedirectCount); end
        step(); step();
        rst_n = 1'b1;
        n_checks++; if (bus.PC !== 32'h2000 || bus.InstValid !== 1'b0) begin n_errors++; $display("FAIL start_cycle1: got pc=%h iv=%b expected pc=00002000 iv=0", bus.PC, bus.InstValid); end
        step();
        n_checks++; if (bus.PC !== 32'h2004 || bus.InstValid !== 1'b1) begin n_errors++; $display("FAIL start_cycle2: got pc=%h iv=%b expected pc=00002004 iv=1", bus.PC, bus.InstValid); end
        n_checks++; if (bus.PCPlus4 !== 32'h2008) begin n_errors++; $display("FAIL start_pcplus4: got %h expected %h", bus.PCPlus4, 32'h2008); end
        step();
        n_checks++; if (bus.PC !== 32'h2008) begin n_errors++; $display("FAIL start_cycle3: got %h expected %h", bus.PC, 32'h2008); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 40 && bus.PC !== 32'h2010; i++) step();
        n_checks++; if (bus.PC !== 32'h2010) begin n_errors++; $display("FAIL redir_reach: got %h expected %h", bus.PC, 32'h2010); end
        bus.ExValid = 1'b1; bus.Diverge = 1'b1; bus.Target = 32'h3001;
        step();
        clear_inputs();
        n_checks++; if (bus.PC !== 32'h3000) begin n_errors++; $display("FAIL redir_pc: got %h expected %h", bus.PC, 32'h3000); end
        n_checks++; if (bus.PCPlus4 !== 32'h3004) begin n_errors++; $display("FAIL redir_pcplus4: got %h expected %h", bus.PCPlus4, 32'h3004); end
        n_checks++; if (bus.InstValid !== 1'b0 || bus.Flush !== 1'b1) begin n_errors++; $display("FAIL redir_qual: got iv=%b fl=%b expected iv=0 fl=1", bus.InstValid, bus.Flush); end
        n_checks++; if (bus.RedirectCount !== 16'd1 || bus.Misaligned !== 1'b0) begin n_errors++; $display("FAIL redir_cnt_mis: got cnt=%0d mis=%b expected cnt=1 mis=0", bus.RedirectCount, bus.Misaligned); end
        step();
        n_checks++; if (bus.PC !== 32'h3004 || bus.Flush !== 1'b1 || bus.InstValid !== 1'b1) begin n_errors++; $display("FAIL redir_second: got pc=%h fl=%b iv=%b expected pc=00003004 fl=1 iv=1", bus.PC, bus.Flush, bus.InstValid); end
        step();
        n_checks++; if (bus.PC !== 32'h3008 || bus.Flush !== 1'b0) begin n_errors++; $display("FAIL redir_third: got pc=%h fl=%b expected pc=00003008 fl=0", bus.PC, bus.Flush); end
    endtask

    task automatic test_ignored_diverge();
        do_reset();
        for (int i = 0; i < 40 && bus.PC !== 32'h2040; i++) step();
        n_checks++; if (bus.PC !== 32'h2040) begin n_errors++; $display("FAIL nodiv_reach: got %h expected %h", bus.PC, 32'h2040); end
        bus.ExValid = 1'b0; bus.Diverge = 1'b1; bus.Target = $urandom;
        step();
        clear_inputs();
        n_checks++; if (bus.PC !== 32'h2044) begin n_errors++; $display("FAIL nodiv_pc: got %h expected %h", bus.PC, 32'h2044); end
        n_checks++; if (bus.Flush !== 1'b0 || bus.RedirectCount !== 16'd0) begin n_errors++; $display("FAIL nodiv_flush_cnt: got fl=%b cnt=%0d expected fl=0 cnt=0", bus.Flush, bus.RedirectCount); end
    endtask

    task automatic test_stall_redirect();
        bus.Stall = 1'b1; bus.ExValid = 1'b1; bus.Diverge = 1'b1; bus.Target = 32'h4000;
        step();
        bus.ExValid = 1'b0; bus.Diverge = 1'b0;
        n_checks++; if (bus.PC !== 32'h4000 || bus.Flush !== 1'b1) begin n_errors++; $display("FAIL stallredir_pc: got pc=%h fl=%b expected pc=00004000 fl=1", bus.PC, bus.Flush); end
        step();
        n_checks++; if (bus.PC !== 32'h4004) begin n_errors++; $display("FAIL stallredir_flush_adv1: got %h expected %h", bus.PC, 32'h4004); end
        step();
        n_checks++; if (bus.PC !== 32'h4008 || bus.Flush !== 1'b0) begin n_errors++; $display("FAIL stallredir_flush_adv2: got pc=%h fl=%b expected pc=00004008 fl=0", bus.PC, bus.Flush); end
        step(); step(); step();
        n_checks++; if (bus.PC !== 32'h4008 || bus.PCPlus4 !== 32'h400C || bus.InstValid !== 1'b1) begin n_errors++; $display("FAIL stallredir_hold: got pc=%h p4=%h iv=%b expected pc=00004008 p4=0000400c iv=1", bus.PC, bus.PCPlus4, bus.InstValid); end
        bus.Stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        int fl;
        do_reset();
        step();
        bus.ExValid = 1'b1; bus.Diverge = 1'b1; bus.Target = 32'h5000;
        step();
        n_checks++; if (bus.PC !== 32'h5000 || bus.Flush !== 1'b1) begin n_errors++; $display("FAIL b2b_first: got pc=%h fl=%b expected pc=00005000 fl=1", bus.PC, bus.Flush); end
        bus.Target = 32'h6002;
        step();
        clear_inputs();
        n_checks++; if (bus.PC !== 32'h6002 || bus.Misaligned !== 1'b1) begin n_errors++; $display("FAIL b2b_second: got pc=%h mis=%b expected pc=00006002 mis=1", bus.PC, bus.Misaligned); end
        n_checks++; if (bus.RedirectCount !== 16'd2) begin n_errors++; $display("FAIL b2b_count: got %0d expected 2", bus.RedirectCount); end
        fl = 2;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.Flush === 1'b1) fl++;
        end
        n_checks++; if (fl !== 3) begin n_errors++; $display("FAIL b2b_flush_len: got %0d expected 3", fl); end
        n_checks++; if (bus.PC !== 32'h6012 || bus.Misaligned !== 1'b1) begin n_errors++; $display("FAIL b2b_after: got pc=%h mis=%b expected pc=00006012 mis=1", bus.PC, bus.Misaligned); end
    endtask

    task automatic test_reset_mid_flush();
        bus.ExValid = 1'b1; bus.Diverge = 1'b1; bus.Target = 32'h7000;
        step();
        clear_inputs();
        n_checks++; if (bus.Flush !== 1'b1) begin n_errors++; $display("FAIL midrst_pre: got fl=%b expected 1", bus.Flush); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (bus.Flush !== 1'b0 || bus.PC !== 32'h2000) begin n_errors++; $display("FAIL midrst_async: got fl=%b pc=%h expected fl=0 pc=00002000", bus.Flush, bus.PC); end
        n_checks++; if (bus.RedirectCount !== 16'd0 || bus.Misaligned !== 1'b0) begin n_errors++; $display("FAIL midrst_cnt: got cnt=%0d mis=%b expected cnt=0 mis=0", bus.RedirectCount, bus.Misaligned); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.PC !== 32'h2004 || bus.InstValid !== 1'b1 || bus.Flush !== 1'b0) begin n_errors++; $display("FAIL midrst_restart: got pc=%h iv=%b fl=%b expected pc=00002004 iv=1 fl=0", bus.PC, bus.InstValid, bus.Flush); end
        step();
        n_checks++; if (bus.Flush !== 1'b0 || bus.PC !== 32'h2008) begin n_errors++; $display("FAIL midrst_no_residual: got fl=%b pc=%h expected fl=0 pc=00002008", bus.Flush, bus.PC); end
    endtask

    task automatic test_random();
        logic m_flush;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                n_checks++; if (bus.PC !== RESET_PC || bus.Flush !== 1'b0 || bus.InstValid !== 1'b0) begin n_errors++; $display("FAIL rand_reset: got pc=%h fl=%b iv=%b expected pc=%h fl=0 iv=0", bus.PC, bus.Flush, bus.InstValid, RESET_PC); end
                step();
                rst_n = 1'b1;
            end
            bus.Stall   = ($urandom_range(0, 9) < 3);
            bus.ExValid = $urandom_range(0, 1) == 1;
            bus.Diverge = ($urandom_range(0, 9) < 2);
            bus.Target  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step();
            m_flush = (m_flush_left > 0);
            n_checks++; if (bus.PC !== m_pc) begin n_errors++; if (n_errors < 20) $display("FAIL rand_pc cyc %0d: got %h expected %h", cyc, bus.PC, m_pc); end
            n_checks++; if (bus.PCPlus4 !== m_pc + 32'd4) begin n_errors++; if (n_errors < 20) $display("FAIL rand_pcplus4 cyc %0d: got %h expected %h", cyc, bus.PCPlus4, m_pc + 32'd4); end
            n_checks++; if (bus.InstValid !== m_valid) begin n_errors++; if (n_errors < 20) $display("FAIL rand_instvalid cyc %0d: got %b expected %b", cyc, bus.InstValid, m_valid); end
            n_checks++; if (bus.Flush !== m_flush) begin n_errors++; if (n_errors < 20) $display("FAIL rand_flush cyc %0d: got %b expected %b", cyc, bus.Flush, m_flush); end
            n_checks++; if (bus.Misaligned !== m_mis) begin n_errors++; if (n_errors < 20) $display("FAIL rand_misaligned cyc %0d: got %b expected %b", cyc, bus.Misaligned, m_mis); end
            n_checks++; if (bus.RedirectCount !== m_count) begin n_errors++; if (n_errors < 20) $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, bus.RedirectCount, m_count); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_ignored_diverge();
        test_stall_redirect();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "time limit");
    end
endmodule
